// File: rtl/ext_reg_mailbox.sv
// ext_reg_mailbox: register-mapped mailbox with a TX and an RX word FIFO,
// a status register, and a level RX-not-empty interrupt.

package core_v_mcu_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

module ext_reg_mailbox #(
  parameter int unsigned Depth = 4,
  parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  reg_req_t    reg_req_i,
  output reg_rsp_t    reg_rsp_o,
  output logic [31:0] ext_tx_data_o,
  output logic        ext_tx_valid_o,
  input  logic        ext_tx_ready_i,
  input  logic [31:0] ext_rx_data_i,
  input  logic        ext_rx_valid_i,
  output logic        ext_rx_ready_o,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q;

  logic [31:0]       tx_mem [Depth];
  logic [31:0]       rx_mem [Depth];
  logic [AW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, clr;
  logic [31:0] status;

  // Address bits above the 32-byte window belong to the parent decoder.
  logic unused_addr;
  assign unused_addr = ^reg_req_i.addr[31:5];

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == LW'(Depth));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == LW'(Depth));

  assign ext_tx_valid_o = ~tx_empty;
  assign ext_tx_data_o  = tx_empty ? 32'h0 : tx_mem[tx_rptr_q];
  assign ext_rx_ready_o = ~rx_full;
  assign tx_pop  = ext_tx_valid_o & ext_tx_ready_i;
  assign rx_push = ext_rx_valid_i & ext_rx_ready_o;
  assign irq_o   = irq_q;

  assign status = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                   rx_empty, rx_full, tx_empty, tx_full};

  // Register handshake: accept in IDLE (side effect now), answer in RESP.
  // The upper half of the 32-byte window (addr[4] set) is reserved.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    clr      = 1'b0;
    if (state_q == RESP) begin
      state_d = IDLE;
    end else if (reg_req_i.valid) begin
      state_d = RESP;
      rdata_d = 32'h0;
      err_d   = 1'b0;
      if (reg_req_i.addr[1:0] != 2'b00 || reg_req_i.addr[4]) begin
        err_d = 1'b1;
      end else begin
        case (reg_req_i.addr[3:2])
          2'd0: if (reg_req_i.write) begin
                  // Full is judged on current state; a same-cycle pop does not help.
                  if (reg_req_i.wstrb != 4'hF || tx_full) err_d = 1'b1;
                  else tx_push = 1'b1;
                end
          2'd1: if (reg_req_i.write || rx_empty) begin
                  err_d = 1'b1;
                end else begin
                  rx_pop  = 1'b1;
                  rdata_d = rx_mem[rx_rptr_q];
                end
          2'd2: if (reg_req_i.write) err_d = 1'b1;
                else rdata_d = status;
          default: if (reg_req_i.write) begin
                  if (reg_req_i.wstrb[0]) begin
                    irq_en_d = reg_req_i.wdata[0];
                    clr      = reg_req_i.wdata[1];
                  end
                end else begin
                  rdata_d = {31'h0, irq_en_q};
                end
        endcase
      end
    end
  end

  // Pointer/level update; a clear overrides any same-cycle external traffic.
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (clr) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + LW'(1);
      if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - LW'(1);
      if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + LW'(1);
      if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - LW'(1);
    end
  end

  // Response drives zero outside RESP so the idle bus is quiet.
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = (state_q == RESP);
    reg_rsp_o.rdata = (state_q == RESP) ? rdata_q : 32'h0;
    reg_rsp_o.error = (state_q == RESP) ? err_q : 1'b0;
  end

  // State registers; irq tracks the enable and RX occupancy one cycle late.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_en_q & ~rx_empty;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO storage; contents are qualified by the levels, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr_q] <= reg_req_i.wdata;
    if (rx_push && !clr) rx_mem[rx_wptr_q] <= ext_rx_data_i;
  end
endmodule

// File: tb/tb_ext_reg_mailbox.sv
// Directed bench for ext_reg_mailbox (Depth = 4).
module tb_ext_reg_mailbox;
  import core_v_mcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  reg_req_t    req;
  reg_rsp_t    rsp;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  int          tests_run = 0;
  int          tests_failed = 0;

  ext_reg_mailbox #(.Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
    .ext_tx_data_o(tx_data), .ext_tx_valid_o(tx_valid), .ext_tx_ready_i(tx_ready),
    .ext_rx_data_i(rx_data), .ext_rx_valid_i(rx_valid), .ext_rx_ready_o(rx_ready),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  // One register access; returns one cycle after the response so the FSM is IDLE again.
  task automatic reg_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    req.valid = 1'b1; req.write = wr; req.addr = addr; req.wdata = wdata; req.wstrb = strb;
    lat = 0; rdata = 32'h0; err = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!rsp.ready && lat < 8);
    rdata = rsp.rdata; err = rsp.error;
    req = '0;
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL latency addr=%h: got %0d cycles want 1", addr, lat); end
    @(posedge clk); #1;
  endtask

  task automatic ext_push(input logic [31:0] d);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic er;
    #12;
    tests_run++; if (rsp !== '0) begin tests_failed++; $display("FAIL reset_rsp: got %h want 0", rsp); end
    tests_run++; if ({tx_valid, rx_ready, irq} !== 3'b010) begin tests_failed++; $display("FAIL reset_flags: got %b want 010", {tx_valid, rx_ready, irq}); end
    tests_run++; if (tx_data !== 32'h0) begin tests_failed++; $display("FAIL reset_txdata: got %h want 0", tx_data); end
    @(negedge clk); rst_n = 1'b1;
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if ({er, rd} !== {1'b0, 32'h0000_000A}) begin tests_failed++; $display("FAIL reset_status: got err=%b %h want err=0 0000000a", er, rd); end
    tests_run++; if ({tx_valid, rx_ready} !== 2'b01) begin tests_failed++; $display("FAIL reset_ports: got %b want 01", {tx_valid, rx_ready}); end
  endtask

  task automatic test_tx_single;
    logic [31:0] rd; logic er;
    reg_acc(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, rd, er);
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL tx1_err: got %b want 0", er); end
    tests_run++; if ({tx_valid, tx_data} !== {1'b1, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL tx1_head: got %b %h want 1 deadbeef", tx_valid, tx_data); end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_0108) begin tests_failed++; $display("FAIL tx1_status: got %h want 00000108", rd); end
    @(negedge clk); tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx1_drain: got valid %b want 0", tx_valid); end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_000A) begin tests_failed++; $display("FAIL tx1_status_empty: got %h want 0000000a", rd); end
  endtask

  task automatic test_tx_full;
    logic [31:0] rd; logic er;
    for (int i = 0; i < 5; i++) begin
      reg_acc(1'b1, 32'h0, 32'hA000_0000 + i, 4'hF, rd, er);
      tests_run++; if (er !== (i == 4)) begin tests_failed++; $display("FAIL txfull_err%0d: got %b want %b", i, er, (i == 4)); end
    end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_0409) begin tests_failed++; $display("FAIL txfull_status: got %h want 00000409", rd); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if ({tx_valid, tx_data} !== {1'b1, 32'hA000_0000 + i}) begin tests_failed++; $display("FAIL txfull_drain%0d: got %b %h want 1 %h", i, tx_valid, tx_data, 32'hA000_0000 + i); end
      tx_ready = 1'b1;
    end
    @(negedge clk); tx_ready = 1'b0;
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL txfull_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_wstrb;
    logic [31:0] rd; logic er;
    reg_acc(1'b1, 32'h0, 32'h5555_5555, 4'h7, rd, er);
    tests_run++; if ({er, tx_valid} !== 2'b10) begin tests_failed++; $display("FAIL wstrb: got err=%b valid=%b want 1 0", er, tx_valid); end
  endtask

  task automatic test_rx_irq;
    logic [31:0] rd; logic er;
    reg_acc(1'b1, 32'hC, 32'h1, 4'hF, rd, er);
    ext_push(32'h11);
    ext_push(32'h22);
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_rise: got %b want 1", irq); end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0002_0002) begin tests_failed++; $display("FAIL rx_status: got %h want 00020002", rd); end
    reg_acc(1'b0, 32'h4, 32'h0, 4'hF, rd, er);
    tests_run++; if ({er, rd} !== {1'b0, 32'h11}) begin tests_failed++; $display("FAIL rx_pop1: got err=%b %h want 0 00000011", er, rd); end
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_hold: got %b want 1", irq); end
    reg_acc(1'b0, 32'h4, 32'h0, 4'hF, rd, er);
    tests_run++; if ({er, rd} !== {1'b0, 32'h22}) begin tests_failed++; $display("FAIL rx_pop2: got err=%b %h want 0 00000022", er, rd); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_fall: got %b want 0", irq); end
    reg_acc(1'b0, 32'h4, 32'h0, 4'hF, rd, er);
    tests_run++; if ({er, rd} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL rx_underflow: got err=%b %h want 1 0", er, rd); end
    reg_acc(1'b1, 32'hC, 32'h0, 4'hE, rd, er);
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL ctrl_nostrb_err: got %b want 0", er); end
    reg_acc(1'b0, 32'hC, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL ctrl_nostrb_keep: got %h want 00000001", rd); end
  endtask

  task automatic test_clear;
    logic [31:0] rd; logic er;
    for (int v = 0; v < 2; v++) begin
      reg_acc(1'b1, 32'h0, 32'hAA, 4'hF, rd, er);
      for (int k = 0; k < (v == 0 ? 4 : 1); k++) ext_push(32'h31 + k);
      if (v == 0) begin
        tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
      end
      @(negedge clk);
      req.valid = 1'b1; req.write = 1'b1; req.addr = 32'hC; req.wdata = 32'h3; req.wstrb = 4'hF;
      rx_valid = 1'b1; rx_data = 32'h55;
      @(posedge clk); #1;
      req = '0; rx_valid = 1'b0;
      tests_run++; if ({rsp.ready, rsp.error} !== 2'b10) begin tests_failed++; $display("FAIL clear%0d_rsp: got %b want 10", v, {rsp.ready, rsp.error}); end
      tests_run++; if ({rx_ready, tx_valid} !== 2'b10) begin tests_failed++; $display("FAIL clear%0d_flush: got %b want 10", v, {rx_ready, tx_valid}); end
      @(posedge clk); #1;
      reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
      tests_run++; if (rd !== 32'h0000_000A) begin tests_failed++; $display("FAIL clear%0d_status: got %h want 0000000a", v, rd); end
      reg_acc(1'b0, 32'hC, 32'h0, 4'hF, rd, er);
      tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL clear%0d_ctrl: got %h want 00000001", v, rd); end
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL clear%0d_irq: got %b want 0", v, irq); end
    end
  endtask

  task automatic test_bad_addr;
    logic [31:0] rd; logic er;
    logic        wr_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ad_t [6] = '{32'h10, 32'h10, 32'h6, 32'h6, 32'h4, 32'h8};
    reg_acc(1'b1, 32'h0, 32'h77, 4'hF, rd, er);
    for (int i = 0; i < 6; i++) begin
      reg_acc(wr_t[i], ad_t[i], 32'h99, 4'hF, rd, er);
      tests_run++; if ({er, rd} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL badaddr%0d: got err=%b %h want 1 0", i, er, rd); end
    end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_0108) begin tests_failed++; $display("FAIL badaddr_status: got %h want 00000108", rd); end
    tests_run++; if (tx_data !== 32'h77) begin tests_failed++; $display("FAIL badaddr_head: got %h want 00000077", tx_data); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er;
    logic [5:0]  seq;
    logic [31:0] exp_t [4] = '{32'h77, 32'h1234, 32'h1234, 32'h1234};
    @(negedge clk);
    req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h0; req.wdata = 32'h1234; req.wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seq[i] = rsp.ready; end
    req = '0;
    tests_run++; if (seq !== 6'b010101) begin tests_failed++; $display("FAIL b2b_ready: got %b want 010101", seq); end
    @(posedge clk); #1;
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_0409) begin tests_failed++; $display("FAIL b2b_status: got %h want 00000409", rd); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if (tx_data !== exp_t[i]) begin tests_failed++; $display("FAIL b2b_drain%0d: got %h want %h", i, tx_data, exp_t[i]); end
      tx_ready = 1'b1;
    end
    @(negedge clk); tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er;
    @(negedge clk);
    req.valid = 1'b1; req.write = 1'b0; req.addr = 32'h8; req.wstrb = 4'hF;
    @(posedge clk); #1;
    tests_run++; if (rsp.ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", rsp.ready); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (rsp !== '0) begin tests_failed++; $display("FAIL mid_abandon: got %h want 0", rsp); end
    req = '0;
    @(negedge clk); rst_n = 1'b1;
    reg_acc(1'b0, 32'hC, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL mid_ctrl: got %h want 0", rd); end
    reg_acc(1'b0, 32'h8, 32'h0, 4'hF, rd, er);
    tests_run++; if (rd !== 32'h0000_000A) begin tests_failed++; $display("FAIL mid_status: got %h want 0000000a", rd); end
  endtask

  initial begin
    req = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;
    test_reset();
    test_tx_single();
    test_tx_full();
    test_wstrb();
    test_rx_irq();
    test_clear();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
